// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Multiplexed N-digit common-anode 7-segment driver with scan
//            counter, per-digit dp, leading-zero blanking and load register.
//            Optional macro SEG_HEX_EN renders digits 10..15 as hex glyphs.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] iDEC,
  input  logic [NUM_DIGITS-1:0]   idp,
  input  logic                    lzb,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       cur_blank;
  logic       zero_run;

  // Returns seg[7:1] ({a..g}), active-low.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
`ifdef SEG_HEX_EN
      4'd10:   s = 7'b0001000;
      4'd11:   s = 7'b1100000;
      4'd12:   s = 7'b0110001;
      4'd13:   s = 7'b1000010;
      4'd14:   s = 7'b0110000;
      4'd15:   s = 7'b0111000;
`endif
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dig_d        = dig_q;
    dp_d         = dp_q;
    seg_d        = 8'hFF;
    an_d         = '1;
    frame_tick_d = 1'b0;
    cur_digit    = 4'd0;
    cur_dp       = 1'b0;
    cur_blank    = 1'b0;
    zero_run     = 1'b1;

    if (load) begin
      dig_d = iDEC;
      dp_d  = idp;
    end

    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        frame_tick_d = (idx_q == IDX_LAST);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Outputs follow idx_d so an/seg switch on the same edge as the index.
    // zero_run walks from the top digit down to detect leading zeros.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (dig_q[4*k +: 4] == 4'd0);
      if (idx_d == IDX_W'(k)) begin
        cur_digit = dig_q[4*k +: 4];
        cur_dp    = dp_q[k];
        cur_blank = lzb && zero_run && (k != 0);
      end
      an_d[k] = !(en && (idx_d == IDX_W'(k)));
    end

    if (en) begin
      seg_d[7:1] = cur_blank ? 7'b1111111 : decode(cur_digit);
      seg_d[0]   = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      dig_q        <= '0;
      dp_q         <= '0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dig_q        <= dig_d;
      dp_q         <= dp_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
